comp_out_tx: RTL and testbench



---
 rtl/comp_out_tx.sv | 163 ++++++++++++++++
 tb/tb_comp_out_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_out_tx.sv
`default_nettype none
// comp_out_tx: emulates the FRIDA comparator output, shifting one queued code per sen frame, MSB first.
// Revision 1.0 - initial release
module comp_out_tx #(
   parameter int unsigned          DATA_BITS = 17,
   parameter int unsigned          DEPTH     = 16,
   parameter logic [DATA_BITS-1:0] IDLE_CODE = '0
) (
   input  logic                     seq_clk,
   input  logic                     rst_b,
   input  logic [DATA_BITS-1:0]     code_data,
   input  logic                     code_valid,
   output logic                     code_ready,
   input  logic                     sclk,
   input  logic                     sen,
   output logic                     comp_out,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [11:0]              frame_cnt,
   input  logic                     clr_flags,
   output logic                     underflow,
   output logic                     short_frame
);

   localparam int unsigned         PTR_W    = $clog2(DEPTH);
   localparam int unsigned         CNT_W    = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(DATA_BITS - 1);
   localparam logic [PTR_W:0]      FULL_LVL = (PTR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [11:0]            frame_cnt_q, frame_cnt_d;
   logic                   underflow_q, underflow_d;
   logic                   short_q, short_d;
   logic                   comp_out_q, comp_out_d;
   logic                   sen_q, sclk_q;
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]         level_q, level_d;
   logic [DATA_BITS-1:0]   mem_q [DEPTH];

   logic sen_rise, sen_fall, sclk_rise;
   logic push, pop, fifo_empty;

   // Both tracks already come from seq_clk flops, so a single register suffices for edge detection.
   assign sen_rise   = sen & ~sen_q;
   assign sen_fall   = ~sen & sen_q;
   assign sclk_rise  = sclk & ~sclk_q;

   assign fifo_empty = (level_q == '0);
   assign code_ready = (level_q != FULL_LVL);
   assign push       = code_valid & code_ready;

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      frame_cnt_d = frame_cnt_q;
      underflow_d = underflow_q & ~clr_flags;
      short_d     = short_q & ~clr_flags;
      pop         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sen_rise) begin
               pop       = ~fifo_empty;
               shreg_d   = fifo_empty ? IDLE_CODE : mem_q[rd_ptr_q];
               bit_cnt_d = '0;
               state_d   = S_SHIFT;
               if (fifo_empty) begin
                  underflow_d = 1'b1;
               end
            end
         end
         S_SHIFT: begin
            if (sen_fall) begin
               short_d     = 1'b1;
               frame_cnt_d = frame_cnt_q + 12'd1;
               state_d     = S_IDLE;
            end else if (sclk_rise) begin
               shreg_d   = {shreg_q[DATA_BITS-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (sen_fall) begin
               frame_cnt_d = frame_cnt_q + 12'd1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + (PTR_W + 1)'(1);
         2'b01:   level_d = level_q - (PTR_W + 1)'(1);
         default: level_d = level_q;
      endcase
   end

   // comp_out follows the current state, giving one cycle of hold after each capture edge.
   assign comp_out_d = (state_q == S_SHIFT) ? shreg_q[DATA_BITS-1] : 1'b0;

   always_ff @(posedge seq_clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         frame_cnt_q <= '0;
         underflow_q <= 1'b0;
         short_q     <= 1'b0;
         comp_out_q  <= 1'b0;
         sen_q       <= 1'b0;
         sclk_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         underflow_q <= underflow_d;
         short_q     <= short_d;
         comp_out_q  <= comp_out_d;
         sen_q       <= sen;
         sclk_q      <= sclk;
         level_q     <= level_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge seq_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= code_data;
      end
   end

   assign comp_out    = comp_out_q;
   assign busy        = (state_q != S_IDLE);
   assign fifo_level  = level_q;
   assign frame_cnt   = frame_cnt_q;
   assign underflow   = underflow_q;
   assign short_frame = short_q;

endmodule
`default_nettype wire

// File: tb/tb_comp_out_tx.sv
`default_nettype none
// tb_comp_out_tx: directed self-checking bench for comp_out_tx.
// Revision 1.0 - initial release
module tb_comp_out_tx;

   logic        seq_clk = 1'b0;
   logic        rst_b;
   logic [16:0] code_data;
   logic        code_valid;
   logic        code_ready;
   logic        sclk;
   logic        sen;
   logic        comp_out;
   logic        busy;
   logic [4:0]  fifo_level;
   logic [11:0] frame_cnt;
   logic        clr_flags;
   logic        underflow;
   logic        short_frame;

   int n_checks = 0;
   int n_pass   = 0;

   comp_out_tx #(
      .DATA_BITS (17),
      .DEPTH     (16),
      .IDLE_CODE (17'h0)
   ) dut (
      .seq_clk     (seq_clk),
      .rst_b       (rst_b),
      .code_data   (code_data),
      .code_valid  (code_valid),
      .code_ready  (code_ready),
      .sclk        (sclk),
      .sen         (sen),
      .comp_out    (comp_out),
      .busy        (busy),
      .fifo_level  (fifo_level),
      .frame_cnt   (frame_cnt),
      .clr_flags   (clr_flags),
      .underflow   (underflow),
      .short_frame (short_frame)
   );

   always #5 seq_clk = ~seq_clk;

   task automatic tick();
      @(posedge seq_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic push_code(input logic [16:0] val);
      code_valid = 1'b1;
      code_data  = val;
      tick();
      code_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
   endtask

   // Receiver model: capture comp_out as seen at each sclk rising edge.
   task automatic run_frame(input int nrise, input logic push_en, input logic [16:0] push_val,
                            output logic [31:0] bits);
      bits       = '0;
      sen        = 1'b1;
      code_valid = push_en;
      code_data  = push_val;
      tick();
      code_valid = 1'b0;
      sclk       = 1'b0;
      tick();
      for (int i = 0; i < nrise; i++) begin
         bits = {bits[30:0], comp_out};
         sclk = 1'b1;
         tick();
         sclk = 1'b0;
         tick();
      end
      sen = 1'b0;
      tick();
      tick();
   endtask

   task automatic fast_frame();
      sen = 1'b1;
      tick();
      sen = 1'b0;
      tick();
   endtask

   function automatic logic [16:0] pat(input int i);
      return 17'(32'h1B00D + i * 32'h0F3D1);
   endfunction

   initial begin
      logic [31:0] bits;
      logic        seen_one;
      int          exp_frames;

      rst_b      = 1'b0;
      code_data  = '0;
      code_valid = 1'b0;
      sclk       = 1'b0;
      sen        = 1'b0;
      clr_flags  = 1'b0;
      tick();
      tick();
      check("rst_comp_out",   32'(comp_out),    32'd0);
      check("rst_busy",       32'(busy),        32'd0);
      check("rst_code_ready", 32'(code_ready),  32'd1);
      check("rst_fifo_level", 32'(fifo_level),  32'd0);
      check("rst_frame_cnt",  32'(frame_cnt),   32'd0);
      check("rst_underflow",  32'(underflow),   32'd0);
      check("rst_short",      32'(short_frame), 32'd0);
      rst_b = 1'b1;
      tick();

      seen_one = 1'b0;
      for (int i = 0; i < 100; i++) begin
         sclk = ~sclk;
         tick();
         seen_one = seen_one | comp_out;
      end
      sclk = 1'b0;
      tick();
      check("idle_comp_out",  32'(seen_one),  32'd0);
      check("idle_frame_cnt", 32'(frame_cnt), 32'd0);

      // Single frame
      push_code(17'h1A5C3);
      check("single_level", 32'(fifo_level), 32'd1);
      run_frame(17, 1'b0, 17'h0, bits);
      exp_frames = 1;
      check("single_bits",      bits,              32'h1A5C3);
      check("single_comp_out",  32'(comp_out),     32'd0);
      check("single_frame_cnt", 32'(frame_cnt),    32'(exp_frames));
      check("single_busy",      32'(busy),         32'd0);
      check("single_flags",     {underflow, short_frame}, 32'd0);

      // Underflow with a push coinciding with the sen rise
      run_frame(17, 1'b1, 17'h0BEEF, bits);
      exp_frames++;
      check("uf_bits",      bits,            32'h0);
      check("uf_flag",      32'(underflow),  32'd1);
      check("uf_level",     32'(fifo_level), 32'd1);
      run_frame(17, 1'b0, 17'h0, bits);
      exp_frames++;
      check("uf_next_bits", bits,            32'h0BEEF);
      check("uf_sticky",    32'(underflow),  32'd1);
      pulse_clr();
      check("uf_clr",       32'(underflow),  32'd0);

      // Short frame then over-long frame
      push_code(17'h12345);
      push_code(17'h0F0F0);
      run_frame(9, 1'b0, 17'h0, bits);
      exp_frames++;
      check("short_bits",      bits,              32'(17'h12345 >> 8));
      check("short_flag",      32'(short_frame),  32'd1);
      check("short_busy",      32'(busy),         32'd0);
      check("short_frame_cnt", 32'(frame_cnt),    32'(exp_frames));
      run_frame(20, 1'b0, 17'h0, bits);
      exp_frames++;
      check("long_bits",  bits[19:3],       32'h0F0F0);
      check("long_tail",  32'(bits[2:0]),   32'd0);
      check("long_level", 32'(fifo_level),  32'd0);
      pulse_clr();
      check("short_clr",  32'(short_frame), 32'd0);

      // FIFO full, extra pushes refused, codes drained in order
      for (int i = 0; i < 18; i++) begin
         if (i == 15) check("ready_before_full", 32'(code_ready), 32'd1);
         if (i == 16) check("ready_full",        32'(code_ready), 32'd0);
         code_valid = 1'b1;
         code_data  = pat(i);
         tick();
      end
      code_valid = 1'b0;
      check("full_level", 32'(fifo_level), 32'd16);
      for (int i = 0; i < 16; i++) begin
         run_frame(17, 1'b0, 17'h0, bits);
         exp_frames++;
         check($sformatf("order_%0d", i), bits, 32'(pat(i)));
      end
      check("drain_level",   32'(fifo_level), 32'd0);
      check("drain_ready",   32'(code_ready), 32'd1);
      check("drain_frames",  32'(frame_cnt),  32'(exp_frames));
      check("drain_flags",   {underflow, short_frame}, 32'd0);

      // frame_cnt wrap
      for (int i = exp_frames; i < 4095; i++) begin
         fast_frame();
      end
      check("pre_wrap_cnt", 32'(frame_cnt), 32'd4095);
      run_frame(17, 1'b0, 17'h0, bits);
      check("wrap_cnt",     32'(frame_cnt), 32'd0);
      pulse_clr();

      // Reset in the middle of a frame
      push_code(17'h1FFFF);
      push_code(17'h15555);
      sen = 1'b1;
      tick();
      sclk = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         sclk = 1'b1;
         tick();
         sclk = 1'b0;
         tick();
      end
      check("mid_comp_out_active", 32'(comp_out), 32'd1);
      rst_b = 1'b0;
      #1;
      check("mid_rst_comp_out", 32'(comp_out),   32'd0);
      check("mid_rst_level",    32'(fifo_level), 32'd0);
      check("mid_rst_busy",     32'(busy),       32'd0);
      sen  = 1'b0;
      sclk = 1'b0;
      tick();
      rst_b = 1'b1;
      tick();
      push_code(17'h00001);
      run_frame(17, 1'b0, 17'h0, bits);
      check("post_rst_bits",  bits,            32'h00001);
      check("post_rst_cnt",   32'(frame_cnt),  32'd1);
      check("post_rst_level", 32'(fifo_level), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
